// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane RISC-V data RAM with post-reset clear sweep; DMEM_OUT_REG_EN adds a second output stage
module dmem_bytelane #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic        WE,
  input  logic        RE,
  input  logic [2:0]  funct3,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        RD_valid,
  output logic        misalign,
  output logic        busy
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] clr_ptr, idx;
  logic [31:0] mem [DEPTH];
  logic [1:0] off, sz;
  logic [3:0] be;
  logic [7:0] byt;
  logic [15:0] half;
  logic [31:0] rdw, wdata, ld_val, rd_q;
  logic align_ok, st_ok, ld_ok, st_req, ld_req, rdv_q, mis_q, unused_a;
  assign unused_a = ^A[31:IDX_W+2];
  assign busy = state == CLEAR;
  always_comb begin
    state_n = (state == CLEAR && clr_ptr == {IDX_W{1'b1}}) ? READY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_n;
      clr_ptr <= (state == CLEAR) ? clr_ptr + IDX_W'(1) : clr_ptr;
    end
  end
  always_comb begin
    off      = A[1:0];
    idx      = A[IDX_W+1:2];
    sz       = funct3[1:0];
    rdw      = mem[idx];
    align_ok = (sz == 2'd0) || (sz == 2'd1 && !A[0]) || (sz == 2'd2 && off == 2'd0);
    st_ok    = !funct3[2] && sz != 2'd3 && align_ok;
    ld_ok    = sz != 2'd3 && !(funct3[2] && sz == 2'd2) && align_ok;
    be       = sz == 2'd0 ? 4'b0001 << off : sz == 2'd1 ? 4'b0011 << off : 4'b1111;
    wdata    = sz == 2'd0 ? {4{WD[7:0]}} : sz == 2'd1 ? {2{WD[15:0]}} : WD;
    byt      = rdw[{off, 3'b000} +: 8];
    half     = rdw[{off[1], 4'b0000} +: 16];
    // funct3[2] selects zero extension for LBU/LHU
    ld_val   = sz == 2'd0 ? {{24{byt[7] & !funct3[2]}}, byt} :
               sz == 2'd1 ? {{16{half[15] & !funct3[2]}}, half} : rdw;
    st_req   = state == READY && WE;
    ld_req   = state == READY && RE && !WE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr] <= CLEAR_VAL;
      else if (st_req && st_ok)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      rdv_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      rdv_q <= ld_req && ld_ok;
      mis_q <= (st_req && !st_ok) || (ld_req && !ld_ok);
      if (ld_req && ld_ok) rd_q <= ld_val;
    end
  end
`ifdef DMEM_OUT_REG_EN
  logic [31:0] rd_q2;
  logic rdv_q2, mis_q2;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q2  <= '0;
      rdv_q2 <= 1'b0;
      mis_q2 <= 1'b0;
    end else begin
      rd_q2  <= rd_q;
      rdv_q2 <= rdv_q;
      mis_q2 <= mis_q;
    end
  end
  assign RD       = rd_q2;
  assign RD_valid = rdv_q2;
  assign misalign = mis_q2;
`else
  assign RD       = rd_q;
  assign RD_valid = rdv_q;
  assign misalign = mis_q;
`endif
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: directed self-checking bench for dmem_bytelane
module tb_dmem_bytelane;
`ifdef DMEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, WE = 0, RE = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] A = 0, WD = 0, RD;
  logic RD_valid, misalign, busy;
  int checks = 0, errors = 0;

  dmem_bytelane #(.DEPTH(1024), .CLEAR_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .RE(RE), .funct3(funct3), .WD(WD),
    .RD(RD), .RD_valid(RD_valid), .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic re, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wd);
    A = a; WE = we; RE = re; funct3 = f; WD = wd;
    tick();
    WE = 0; RE = 0;
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 00000000", RD); end
    checks++; if (RD_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b expected 0", RD_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", misalign); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
  endtask

  task automatic test_sweep();
    int n = 0;
    logic seen = 0;
    rst = 0; RE = 1; funct3 = 3'b010; A = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
      if (RD_valid || misalign) seen = 1;
    end
    RE = 0;
    checks++; if (n != 1024) begin errors++; $display("FAIL sweep_len: got %0d expected 1024", n); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_ignore: got %b expected 0", seen); end
    req(0, 1, 3'b010, 32'h0, 0);
    checks++; if (RD !== 32'h0 || RD_valid !== 1'b1) begin errors++; $display("FAIL clear_lw: got %h/%b expected 00000000/1", RD, RD_valid); end
  endtask

  task automatic test_word();
    req(1, 0, 3'b010, 32'h100, 32'hDEADBEEF);
    checks++; if (RD_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL sw_flags: got %b%b expected 00", RD_valid, misalign); end
    req(0, 1, 3'b010, 32'h100, 0);
    checks++; if (RD !== 32'hDEADBEEF || RD_valid !== 1'b1) begin errors++; $display("FAIL word_lw: got %h/%b expected deadbeef/1", RD, RD_valid); end
    tick();
    checks++; if (RD_valid !== 1'b0 || RD !== 32'hDEADBEEF) begin errors++; $display("FAIL rdv_pulse: got %b/%h expected 0/deadbeef", RD_valid, RD); end
  endtask

  task automatic test_lanes();
    req(1, 0, 3'b010, 32'h200, 32'h11223344);
    req(1, 0, 3'b000, 32'h201, 32'h00000080);
    req(0, 1, 3'b010, 32'h200, 0);
    checks++; if (RD !== 32'h11228044) begin errors++; $display("FAIL lane_lw: got %h expected 11228044", RD); end
    req(0, 1, 3'b000, 32'h201, 0);
    checks++; if (RD !== 32'hFFFFFF80) begin errors++; $display("FAIL lane_lb: got %h expected ffffff80", RD); end
    req(0, 1, 3'b100, 32'h201, 0);
    checks++; if (RD !== 32'h00000080) begin errors++; $display("FAIL lane_lbu: got %h expected 00000080", RD); end
    req(0, 1, 3'b001, 32'h202, 0);
    checks++; if (RD !== 32'h00001122) begin errors++; $display("FAIL lane_lh: got %h expected 00001122", RD); end
    req(1, 0, 3'b001, 32'h202, 32'h1234BEEF);
    req(0, 1, 3'b001, 32'h202, 0);
    checks++; if (RD !== 32'hFFFFBEEF) begin errors++; $display("FAIL sh_lh: got %h expected ffffbeef", RD); end
    req(0, 1, 3'b101, 32'h202, 0);
    checks++; if (RD !== 32'h0000BEEF) begin errors++; $display("FAIL sh_lhu: got %h expected 0000beef", RD); end
    req(0, 1, 3'b010, 32'h200, 0);
    checks++; if (RD !== 32'hBEEF8044) begin errors++; $display("FAIL sh_lw: got %h expected beef8044", RD); end
  endtask

  task automatic test_misalign();
    req(0, 1, 3'b001, 32'h103, 0);
    checks++; if (misalign !== 1'b1 || RD_valid !== 1'b0 || RD !== 32'hBEEF8044) begin errors++; $display("FAIL mis_lh: got %b/%b/%h expected 1/0/beef8044", misalign, RD_valid, RD); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", misalign); end
    req(1, 0, 3'b010, 32'h102, 32'h12345678);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_sw: got %b expected 1", misalign); end
    req(1, 0, 3'b011, 32'h100, 32'h0);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL ill_st: got %b expected 1", misalign); end
    req(0, 1, 3'b011, 32'h100, 0);
    checks++; if (misalign !== 1'b1 || RD_valid !== 1'b0) begin errors++; $display("FAIL ill_ld: got %b/%b expected 1/0", misalign, RD_valid); end
    req(0, 1, 3'b110, 32'h100, 0);
    checks++; if (misalign !== 1'b1 || RD_valid !== 1'b0) begin errors++; $display("FAIL ill_ld110: got %b/%b expected 1/0", misalign, RD_valid); end
    req(0, 1, 3'b010, 32'h100, 0);
    checks++; if (RD !== 32'hDEADBEEF || misalign !== 1'b0) begin errors++; $display("FAIL mis_nowrite: got %h/%b expected deadbeef/0", RD, misalign); end
  endtask

  task automatic test_wrap_arb();
    req(1, 0, 3'b010, 32'h1000, 32'hA5A5A5A5);
    req(0, 1, 3'b010, 32'h0, 0);
    checks++; if (RD !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_lw: got %h expected a5a5a5a5", RD); end
    req(1, 1, 3'b010, 32'h4, 32'h55AA55AA);
    checks++; if (RD_valid !== 1'b0 || RD !== 32'hA5A5A5A5) begin errors++; $display("FAIL arb_rdv: got %b/%h expected 0/a5a5a5a5", RD_valid, RD); end
    req(0, 1, 3'b010, 32'h4, 0);
    checks++; if (RD !== 32'h55AA55AA) begin errors++; $display("FAIL arb_store: got %h expected 55aa55aa", RD); end
  endtask

  task automatic test_back_to_back();
    req(0, 1, 3'b010, 32'h100, 0);
    checks++; if (RD !== 32'hDEADBEEF || RD_valid !== 1'b1) begin errors++; $display("FAIL b2b_0: got %h/%b expected deadbeef/1", RD, RD_valid); end
    req(0, 1, 3'b010, 32'h200, 0);
    checks++; if (RD !== 32'hBEEF8044 || RD_valid !== 1'b1) begin errors++; $display("FAIL b2b_1: got %h/%b expected beef8044/1", RD, RD_valid); end
    req(0, 1, 3'b100, 32'h203, 0);
    checks++; if (RD !== 32'h000000BE || RD_valid !== 1'b1) begin errors++; $display("FAIL b2b_2: got %h/%b expected 000000be/1", RD, RD_valid); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    rst = 1; tick(); rst = 0;
    repeat (500) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1; tick();
    checks++; if (RD !== 32'h0 || busy !== 1'b1) begin errors++; $display("FAIL mid_rst: got %h/%b expected 00000000/1", RD, busy); end
    rst = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    checks++; if (n != 1024) begin errors++; $display("FAIL mid_sweep_len: got %0d expected 1024", n); end
    req(0, 1, 3'b010, 32'h100, 0);
    checks++; if (RD !== 32'h0 || RD_valid !== 1'b1) begin errors++; $display("FAIL mid_clear: got %h/%b expected 00000000/1", RD, RD_valid); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_word();
    test_lanes();
    test_misalign();
    test_wrap_arb();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor to the single-cycle core's word-only data memory.
- Single-port, byte-addressable, little-endian RAM, DEPTH words of 32 bits.
- Supports RISC-V sized loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane enables, sign/zero extension and misalignment detection.
- After reset, a hardware clear sweep zeroes the array before any access is accepted.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, at least 4.
CLEAR_VAL, 32'h0000_0000, value written to every word during the post-reset sweep.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
A  input  32  byte address
WE  input  1  store request
RE  input  1  load request
funct3  input  3  RISC-V access size/sign field
WD  input  32  store data, right-aligned
RD  output  32  load result, extended to 32 bits
RD_valid  output  1  one-cycle pulse: RD updated
misalign  output  1  one-cycle pulse: previous request rejected
busy  output  1  clear sweep in progress; requests ignored

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Word index: A[IDX_W+1:2], where IDX_W = log2(DEPTH). Upper address bits are ignored, so addresses wrap modulo DEPTH*4. Lane offset: A[1:0].
- FSM states:
  - CLEAR: entered on rst. clr_ptr=0. Each cycle writes CLEAR_VAL to mem[clr_ptr] and increments clr_ptr. The cycle that writes clr_ptr==DEPTH-1 transitions to READY.
  - READY: services requests. Stays in READY until rst.
- Reset values: RD=0, RD_valid=0, misalign=0, busy=1, state=CLEAR.
- busy is high for exactly DEPTH cycles after the cycle in which rst is sampled low.
- Reset during CLEAR or READY restarts the sweep from index 0.
- While busy, WE/RE are ignored: no write, no RD_valid, no misalign.
- In READY, WE and RE together: WE wins; the request is a store only and RD_valid stays 0.
- Stores (WE=1):
  - funct3=000 SB: lane enable 0001<<A[1:0], byte WD[7:0] replicated to all lanes.
  - funct3=001 SH: A[0] must be 0; lane enable 0011<<A[1:0], half WD[15:0] replicated.
  - funct3=010 SW: A[1:0] must be 00; all lanes, WD.
  - Other funct3 values or a failed alignment check: no write, misalign=1 next cycle.
  - Only enabled lanes change; all other bytes are preserved.
- Loads (RE=1, WE=0):
  - Read word selected by A. Extract byte/half by A[1:0].
  - funct3 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
  - Alignment rules are the same as for stores. Other funct3 values are illegal.
  - Legal load: RD and RD_valid=1 on the next cycle (latency 1).
  - Illegal or misaligned load: RD unchanged, RD_valid=0, misalign=1 next cycle.
- RD holds its last value between loads. RD_valid and misalign are single-cycle pulses.
- A store at cycle N followed by a load to the same word at cycle N+1 returns the stored data; there is no hazard.
- Back-to-back loads sustain one per cycle.
- Memory contents are undefined only before the first sweep completes. No initial-block preload is used.

Optional Feature:
- Macro: DMEM_OUT_REG_EN.
- Defined: adds a second output register stage.
  - RD, RD_valid and misalign are delayed one extra cycle (load latency 2, misalign latency 2).
  - Throughput is still one request per cycle.
  - rst clears both stages.
- Undefined: latency 1 as specified above.

Test Plan:
- Sweep: assert rst 2 cycles, then release -> busy=1 for exactly 1024 cycles. A load of 0x0 issued during busy yields no RD_valid. After the sweep, LW 0x0 -> RD=0x00000000.
- Word path: SW A=0x100 WD=0xDEADBEEF, next cycle LW 0x100 -> RD=0xDEADBEEF with RD_valid one cycle after the request.
- Byte/half lanes: SW 0x200=0x11223344, then SB A=0x201 WD=0x80, then:
  - LW 0x200 -> 0x11228044
  - LB 0x201 -> 0xFFFFFF80
  - LBU 0x201 -> 0x00000080
  - LH 0x202 -> 0x00001122
- Misalignment: LH A=0x103 -> misalign pulse, RD_valid=0, RD unchanged. SW A=0x102 -> misalign pulse, memory unchanged.
- Illegal funct3: funct3=011 on a load or store -> misalign pulse, no write.
- Wrap and arbitration:
  - SW A=0x1000 WD=0xA5A5A5A5, then LW 0x0 -> 0xA5A5A5A5 (DEPTH=1024).
  - WE=RE=1 at 0x4 -> store performed, no RD_valid.
  - rst asserted mid-sweep at index 500 -> busy is high for another full 1024 cycles.
